uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART_TX transmitter between NUM_REQ byte-stream requesters.
- Each requester presents bytes on a valid/ready handshake.
- Arbitration is round-robin at packet granularity: once granted, a requester keeps the transmitter until its byte flagged last has been sent, or until its lock times out.
- Sits between the requesters and UART_TX. It drives tx_start/d_in and consumes tx_done; BAUDGEN and UART_TX are not modified.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- LOCK_TIMEOUT, 65536, idle clk cycles a granted requester may leave the transmitter starved mid-packet before its lock is released. 0 disables the timeout.

Ports:
- clk  in  1  system clock (50 MHz in the standard bench)
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte of requester i, bits [8i+7:8i]
- req_last  in  NUM_REQ  byte of requester i ends its packet
- req_ready  out  NUM_REQ  one-hot; byte of requester i accepted this cycle
- tx_start  out  1  one-cycle start pulse to UART_TX
- tx_d_in  out  8  byte to UART_TX; stable from tx_start until tx_done
- tx_done  in  1  one-cycle completion pulse from UART_TX
- grant_id  out  $clog2(NUM_REQ) (min 1)  current owner; valid while busy
- busy  out  1  a packet is in progress (lock held)
- lock_timeout  out  1  one-cycle pulse when a lock is released by timeout
- spurious_done  out  1  sticky; tx_done seen outside WAIT_DONE

Behaviour:
- Reset (async, resetn=0):
  - State is IDLE; rr pointer is 0.
  - All outputs are 0: req_ready, tx_start, tx_d_in, grant_id, busy, lock_timeout, spurious_done.
  - Lock counter is cleared.
- States: IDLE, START, WAIT_DONE, HOLD.
- IDLE:
  - Pick the first i with req_valid[i], scanning from the rr pointer upward with wrap.
  - Assert req_ready[i] combinationally in that same cycle.
  - Capture req_data[i] into tx_d_in and req_last[i] into the last flag.
  - Set grant_id=i, busy=1, go to START.
  - No valid request: stay in IDLE.
- START: tx_start=1 for exactly one cycle, then go to WAIT_DONE.
  - Latency is one cycle: a byte accepted in cycle k gives tx_start in cycle k+1.
- WAIT_DONE: hold tx_d_in stable; req_ready=0. On tx_done:
  - If last flag set: busy=0, rr pointer = grant_id+1 (wraps modulo NUM_REQ), go to IDLE.
  - Otherwise: clear the lock counter and go to HOLD.
- HOLD: only requester grant_id is considered.
  - req_valid[grant_id]=1: req_ready[grant_id]=1, capture byte and last flag, go to START.
  - Otherwise increment the lock counter.
  - If LOCK_TIMEOUT!=0 and the counter reaches LOCK_TIMEOUT-1:
    - Pulse lock_timeout.
    - Set busy=0 and rr pointer = grant_id+1.
    - Go to IDLE.
- Arbitration:
  - Simultaneous valids in IDLE resolve by the rr scan; exactly one req_ready is high.
  - Other requesters' valid/data are ignored while busy.
- Requester contract: data and last are held while valid is high and ready is low. Valid may drop at any time before acceptance.
- tx_done arriving in IDLE, START or HOLD: ignored for state, spurious_done set. spurious_done is cleared only by reset.
- Reset mid-frame (any state): immediately returns to reset values. The in-flight byte is lost; no tx_start is issued after resetn rises until a new acceptance.
- NUM_REQ=1: the rr pointer is a constant 0 and behaviour is otherwise identical.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state enum arb_state_t {IDLE, START, WAIT_DONE, HOLD};
  - localparam function idw(n) = max(1, $clog2(n));
  - default NUM_REQ and LOCK_TIMEOUT constants.
- One sub-module, uart_tx_rr_picker.
  - Parameter: NUM_REQ.
  - Inputs: req vector, rr pointer.
  - Outputs: found, index.
  - Purely combinational rotate-scan; reused by later arbiters.
- FSM, capture registers and lock counter stay in uart_tx_arbiter.

Test Plan:
- Single byte: req0 sends 0xA5 with last=1.
  - req_ready[0] pulses once; tx_start follows one cycle later with tx_d_in=0xA5.
  - tx line shows start bit, 10100101 LSB-first, stop bit at 19200 baud.
  - busy drops on tx_done; next rr pointer is 1.
- Fairness: all 4 requesters hold single-byte packets 0x10,0x20,0x30,0x40 continuously.
  - Order of transmission is 0,1,2,3,0,...
  - Exactly one req_ready per accept; no tx_start while in WAIT_DONE.
- Packet lock: req1 sends 0x01,0x02,0x03 (last on 0x03) while req2 stays valid with 0xFF.
  - Bytes 01 02 03 go out contiguously; 0xFF follows; grant_id=1 for the whole packet.
- Timeout (LOCK_TIMEOUT=100): req0 sends 0x55 with last=0, then drops valid; req3 waits with 0x77.
  - lock_timeout pulses 100 cycles after the HOLD entry.
  - 0x77 is then granted; no further bytes from req0 under the stale lock.
- Reset mid-frame: assert resetn=0 during WAIT_DONE of byte 0x3C.
  - All outputs read 0 while resetn=0.
  - After release with no valid requests, tx_start stays 0 for 1000 cycles.
- Spurious done: force tx_done=1 for one cycle in IDLE.
  - spurious_done=1 and stays set.
  - State stays IDLE; no req_ready or tx_start.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmitter arbiter family.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, HOLD} arb_state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_LOCK_TIMEOUT = 65536;

  // Width of a requester index; never narrower than one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshakes plus the start/data/done link to UART_TX.
interface uart_tx_arbiter_if
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_d_in;
  logic                 tx_done;

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_start, tx_d_in
  );

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_start, tx_d_in
  );

endinterface

// File: rtl/uart_tx_rr_picker.sv
// Combinational round-robin scan: first asserted request at or above ptr, with wrap.
module uart_tx_rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     index
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        found = 1'b1;
        index = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART_TX among NUM_REQ byte streams.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ      = DEF_NUM_REQ,
  parameter  int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  localparam int IDW          = idw(NUM_REQ)
) (
  input  logic               clk,
  input  logic               resetn,
  uart_tx_arbiter_if.slave   bus,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               lock_timeout,
  output logic               spurious_done
);

  localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  arb_state_t         state, state_nx;
  logic [IDW-1:0]     rr_ptr;
  logic               last_flag;
  logic [CNT_W-1:0]   lock_cnt;
  logic [7:0]         tx_byte;

  logic               pick_found;
  logic [IDW-1:0]     pick_idx;

  logic [NUM_REQ-1:0] req_ready;
  logic               accept;
  logic [IDW-1:0]     acc_idx;
  logic               release_lock;
  logic               timeout_hit;
  logic               cnt_clr;
  logic               cnt_inc;

  logic [7:0]         sel_byte;
  logic               sel_last;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
    return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  uart_tx_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign sel_byte      = bus.req_data[{acc_idx, 3'b000} +: 8];
  assign sel_last      = bus.req_last[acc_idx];
  assign bus.req_ready = req_ready;
  assign bus.tx_start  = (state == START);
  assign bus.tx_d_in   = tx_byte;

  always_comb begin
    state_nx     = state;
    req_ready    = '0;
    accept       = 1'b0;
    acc_idx      = grant_id;
    release_lock = 1'b0;
    timeout_hit  = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          req_ready[pick_idx] = 1'b1;
          accept              = 1'b1;
          acc_idx             = pick_idx;
          state_nx            = START;
        end
      end
      START: state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (last_flag) begin
            release_lock = 1'b1;
            state_nx     = IDLE;
          end else begin
            cnt_clr  = 1'b1;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        // Only the lock owner may continue; everyone else waits for release.
        if (bus.req_valid[grant_id]) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_nx            = START;
        end else if (LOCK_TIMEOUT != 0 && lock_cnt == LAST_CNT) begin
          timeout_hit  = 1'b1;
          release_lock = 1'b1;
          state_nx     = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      last_flag     <= 1'b0;
      lock_cnt      <= '0;
      tx_byte       <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      lock_timeout  <= 1'b0;
      spurious_done <= 1'b0;
    end else begin
      state        <= state_nx;
      lock_timeout <= timeout_hit;
      if (bus.tx_done && state != WAIT_DONE) spurious_done <= 1'b1;
      if (accept) begin
        tx_byte   <= sel_byte;
        last_flag <= sel_last;
        grant_id  <= acc_idx;
        busy      <= 1'b1;
      end
      if (release_lock) begin
        busy   <= 1'b0;
        rr_ptr <= wrap_inc(grant_id);
      end
      if (cnt_clr)      lock_cnt <= '0;
      else if (cnt_inc) lock_cnt <= lock_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART_TX done generator.
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int N   = 4;
  localparam int DLY = 12;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] grant_id;
  logic       busy, lock_timeout, spurious_done;
  logic       gen_done = 1'b0;
  logic       man_done = 1'b0;

  int tests = 0;
  int fails = 0;
  int gcnt = 0;
  int overlap = 0;
  int ready_viol = 0;
  int start_count = 0;
  logic [7:0] sent[$];
  logic [1:0] sent_gid[$];

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(100)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .grant_id      (grant_id),
    .busy          (busy),
    .lock_timeout  (lock_timeout),
    .spurious_done (spurious_done)
  );

  assign bus.tx_done = gen_done | man_done;

  always #5 clk = ~clk;

  // UART_TX stand-in plus transmit log, all on the falling edge.
  always @(negedge clk) begin
    gen_done = 1'b0;
    if ((bus.req_ready & ~bus.req_valid) != '0 || $countones(bus.req_ready) > 1) ready_viol++;
    if (!resetn) begin
      gcnt = 0;
    end else if (bus.tx_start) begin
      if (gcnt != 0) overlap++;
      gcnt = DLY;
      start_count++;
      sent.push_back(bus.tx_d_in);
      sent_gid.push_back(grant_id);
    end else if (gcnt != 0) begin
      gcnt--;
      if (gcnt == 0) gen_done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 500), 1);
  endtask

  task automatic wait_ready(input int idx, input string tag);
    int n = 0;
    while (bus.req_ready[idx] !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 2000), 1);
  endtask

  task automatic wait_sent(input int cnt, input string tag);
    int n = 0;
    while (sent.size() < cnt && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 3000), 1);
  endtask

  logic [7:0] fair_exp [8] = '{8'h20, 8'h30, 8'h40, 8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
  logic [1:0] fair_gid [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] pkt_bytes [3] = '{8'h01, 8'h02, 8'h03};

  initial begin
    int n;
    int s0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;

    // Reset values
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_start", 32'(bus.tx_start), 0);
    chk("rst_d_in", 32'(bus.tx_d_in), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(lock_timeout), 0);
    chk("rst_spurious", 32'(spurious_done), 0);
    resetn = 1'b1;
    tick();

    // Single byte from req0
    bus.req_valid = 4'b0001;
    bus.req_data  = {8'h40, 8'h30, 8'h20, 8'hA5};
    bus.req_last  = 4'b0001;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("single_start", 32'(bus.tx_start), 1);
    chk("single_d_in", 32'(bus.tx_d_in), 32'hA5);
    chk("single_busy", 32'(busy), 1);
    chk("single_ready_off", 32'(bus.req_ready), 0);
    tick();
    chk("single_start_off", 32'(bus.tx_start), 0);
    chk("single_d_hold", 32'(bus.tx_d_in), 32'hA5);
    wait_idle("single_idle");
    chk("single_count", 32'(sent.size()), 1);
    chk("single_byte", 32'(sent[0]), 32'hA5);

    // Fairness: all four requesters continuously valid; rr pointer now 1
    sent.delete();
    sent_gid.delete();
    bus.req_valid = 4'b1111;
    bus.req_data  = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.req_last  = 4'b1111;
    wait_sent(8, "fair_progress");
    bus.req_valid = '0;
    wait_idle("fair_idle");
    chk("fair_count", 32'(sent.size()), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fair_byte%0d", i), 32'(sent[i]), 32'(fair_exp[i]));
      chk($sformatf("fair_gid%0d", i), 32'(sent_gid[i]), 32'(fair_gid[i]));
    end

    // Packet lock: req1 sends 01 02 03 while req2 waits with FF; rr pointer now 1
    sent.delete();
    sent_gid.delete();
    bus.req_data[23:16] = 8'hFF;
    bus.req_last[2]     = 1'b1;
    bus.req_valid[2]    = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.req_data[15:8] = pkt_bytes[b];
      bus.req_last[1]    = (b == 2);
      bus.req_valid[1]   = 1'b1;
      #1;
      wait_ready(1, $sformatf("lock_accept%0d", b));
      tick();
    end
    bus.req_valid[1] = 1'b0;
    wait_sent(4, "lock_progress");
    bus.req_valid = '0;
    wait_idle("lock_idle");
    chk("lock_count", 32'(sent.size()), 4);
    chk("lock_b0", 32'(sent[0]), 32'h01);
    chk("lock_b1", 32'(sent[1]), 32'h02);
    chk("lock_b2", 32'(sent[2]), 32'h03);
    chk("lock_b3", 32'(sent[3]), 32'hFF);
    chk("lock_g0", 32'(sent_gid[0]), 1);
    chk("lock_g1", 32'(sent_gid[1]), 1);
    chk("lock_g2", 32'(sent_gid[2]), 1);
    chk("lock_g3", 32'(sent_gid[3]), 2);

    // Timeout: req0 sends 55 without last, then goes silent; req3 waits with 77
    sent.delete();
    sent_gid.delete();
    bus.req_data[7:0]   = 8'h55;
    bus.req_last        = 4'b1000;
    bus.req_data[31:24] = 8'h77;
    bus.req_valid       = 4'b0001;
    #1;
    wait_ready(0, "to_accept");
    tick();
    bus.req_valid = 4'b1000;
    n = 0;
    while (bus.tx_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("to_done_seen", 32'(n < 200), 1);
    chk("to_busy_hold", 32'(busy), 1);
    n = 0;
    while (lock_timeout !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 100);
    chk("to_busy_rel", 32'(busy), 0);
    tick();
    chk("to_pulse_width", 32'(lock_timeout), 0);
    wait_sent(2, "to_progress");
    bus.req_valid = '0;
    wait_idle("to_idle");
    chk("to_count", 32'(sent.size()), 2);
    chk("to_b0", 32'(sent[0]), 32'h55);
    chk("to_b1", 32'(sent[1]), 32'h77);
    chk("to_g1", 32'(sent_gid[1]), 3);

    // Reset during WAIT_DONE of 3C
    sent.delete();
    sent_gid.delete();
    bus.req_data[23:16] = 8'h3C;
    bus.req_last        = 4'b0100;
    bus.req_valid       = 4'b0100;
    #1;
    wait_ready(2, "rmf_accept");
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    chk("rmf_busy_before", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    chk("rmf_d_in", 32'(bus.tx_d_in), 0);
    chk("rmf_busy", 32'(busy), 0);
    chk("rmf_grant", 32'(grant_id), 0);
    chk("rmf_start", 32'(bus.tx_start), 0);
    chk("rmf_ready", 32'(bus.req_ready), 0);
    tick();
    tick();
    resetn = 1'b1;
    s0 = start_count;
    repeat (1000) tick();
    chk("rmf_no_start", 32'(start_count - s0), 0);
    chk("rmf_spurious", 32'(spurious_done), 0);

    // Spurious tx_done in IDLE
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("sp_flag", 32'(spurious_done), 1);
    chk("sp_busy", 32'(busy), 0);
    chk("sp_ready", 32'(bus.req_ready), 0);
    s0 = start_count;
    repeat (5) tick();
    chk("sp_sticky", 32'(spurious_done), 1);
    chk("sp_no_start", 32'(start_count - s0), 0);
    bus.req_data[15:8] = 8'h5A;
    bus.req_last       = 4'b0010;
    bus.req_valid      = 4'b0010;
    #1;
    chk("sp_idle_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    chk("sp_after_start", 32'(bus.tx_start), 1);
    chk("sp_after_d_in", 32'(bus.tx_d_in), 32'h5A);
    wait_idle("sp_after_idle");
    chk("sp_still_set", 32'(spurious_done), 1);

    chk("ready_onehot", 32'(ready_viol), 0);
    chk("start_overlap", 32'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
